reset_sequencer: RTL and testbench

Staged reset-release controller in the `clk_a` domain. It consumes the synchronized, active-low system reset and releases the downstream subsystem resets in a fixed order:

- SDRAM controller first.
- CPU only after the SDRAM controller reports init done.
- Peripherals last.

It also supports a software-requested warm reset of CPU and peripherals, and retries SDRAM bring-up on an init timeout.

---
 rtl/reset_sequencer.sv | 148 ++++++++++++++
 tb/tb_reset_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset-release controller: SDRAM, then CPU once SDRAM init is done,
// then peripherals. Also handles warm (soft) resets and SDRAM init timeouts.
module reset_sequencer #(
  parameter int STAGE_DELAY  = 16,
  parameter int INIT_TIMEOUT = 65535,
  parameter int SOFT_RST_LEN = 32
) (
  input  logic clk_a,
  input  logic resetn_a,
  input  logic sdram_init_done,
  input  logic soft_reset_req,
  output logic sdram_resetn,
  output logic cpu_resetn,
  output logic periph_resetn,
  output logic seq_done,
  output logic init_timeout_err
);

  localparam int MAX_AB  = (STAGE_DELAY > INIT_TIMEOUT) ? STAGE_DELAY : INIT_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > SOFT_RST_LEN) ? MAX_AB : SOFT_RST_LEN;
  localparam int CW      = $clog2(MAX_CNT + 1);

  // Terminal counts: every state leaves on the edge its counter reaches these.
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_TIMEOUT - 1);
  localparam logic [CW-1:0] SOFT_LAST  = CW'(SOFT_RST_LEN - 1);

  typedef enum logic [2:0] {
    HOLD,
    WAIT_INIT,
    CPU_DLY,
    PERIPH_DLY,
    RUN,
    SOFT
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          sdram_resetn_reg, sdram_resetn_next;
  logic          cpu_resetn_reg, cpu_resetn_next;
  logic          periph_resetn_reg, periph_resetn_next;
  logic          timeout_err_reg, timeout_err_next;
  logic          soft_prev_reg;
  logic          soft_rise;

  assign soft_rise = soft_reset_req & ~soft_prev_reg;

  always_ff @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) begin
      state_reg         <= HOLD;
      cnt_reg           <= '0;
      sdram_resetn_reg  <= 1'b0;
      cpu_resetn_reg    <= 1'b0;
      periph_resetn_reg <= 1'b0;
      timeout_err_reg   <= 1'b0;
      soft_prev_reg     <= 1'b1;  // a request held high through reset never looks like an edge
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      sdram_resetn_reg  <= sdram_resetn_next;
      cpu_resetn_reg    <= cpu_resetn_next;
      periph_resetn_reg <= periph_resetn_next;
      timeout_err_reg   <= timeout_err_next;
      soft_prev_reg     <= soft_reset_req;
    end
  end

  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    sdram_resetn_next  = sdram_resetn_reg;
    cpu_resetn_next    = cpu_resetn_reg;
    periph_resetn_next = periph_resetn_reg;
    timeout_err_next   = timeout_err_reg;

    case (state_reg)
      HOLD: begin
        if (cnt_reg == STAGE_LAST) begin
          sdram_resetn_next = 1'b1;
          cnt_next          = '0;
          state_next        = WAIT_INIT;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      WAIT_INIT: begin
        // Init done takes priority over a coincident timeout.
        if (sdram_init_done) begin
          cnt_next   = '0;
          state_next = CPU_DLY;
        end else if (cnt_reg == INIT_LAST) begin
          timeout_err_next  = 1'b1;
          sdram_resetn_next = 1'b0;
          cnt_next          = '0;
          state_next        = HOLD;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      CPU_DLY: begin
        if (cnt_reg == STAGE_LAST) begin
          cpu_resetn_next = 1'b1;
          cnt_next        = '0;
          state_next      = PERIPH_DLY;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      PERIPH_DLY: begin
        if (cnt_reg == STAGE_LAST) begin
          periph_resetn_next = 1'b1;
          cnt_next           = '0;
          state_next         = RUN;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RUN: begin
        if (soft_rise) begin
          cpu_resetn_next    = 1'b0;
          periph_resetn_next = 1'b0;
          cnt_next           = '0;
          state_next         = SOFT;
        end
      end
      SOFT: begin
        // Warm reset rejoins the cold sequence after SDRAM bring-up.
        if (cnt_reg == SOFT_LAST) begin
          cnt_next   = '0;
          state_next = CPU_DLY;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = HOLD;
      end
    endcase
  end

  assign sdram_resetn     = sdram_resetn_reg;
  assign cpu_resetn       = cpu_resetn_reg;
  assign periph_resetn    = periph_resetn_reg;
  assign seq_done         = periph_resetn_reg;
  assign init_timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: an event-schedule model checked every cycle,
// directed scenarios with literal edge numbers, and a randomized soak.
module tb_reset_sequencer;
  localparam int S = 4;
  localparam int T = 20;
  localparam int L = 8;

  logic clk_a = 1'b0;
  logic resetn_a = 1'b0;
  logic sdram_init_done = 1'b0;
  logic soft_reset_req = 1'b0;
  logic sdram_resetn, cpu_resetn, periph_resetn, seq_done, init_timeout_err;

  int total = 0;
  int bad = 0;

  reset_sequencer #(
    .STAGE_DELAY(S),
    .INIT_TIMEOUT(T),
    .SOFT_RST_LEN(L)
  ) dut (
    .clk_a(clk_a),
    .resetn_a(resetn_a),
    .sdram_init_done(sdram_init_done),
    .soft_reset_req(soft_reset_req),
    .sdram_resetn(sdram_resetn),
    .cpu_resetn(cpu_resetn),
    .periph_resetn(periph_resetn),
    .seq_done(seq_done),
    .init_timeout_err(init_timeout_err)
  );

  always #5 clk_a = ~clk_a;

  // Model: edge number since reset release plus the edges at which each
  // release is scheduled to happen.
  int   e = 0;
  int   sd_up_at = S, win_start = -1, cpu_up_at = -1, per_up_at = -1;
  logic m_sd = 0, m_cpu = 0, m_per = 0, m_err = 0, m_prev = 1;
  logic rise, was_run;

  always @(posedge clk_a or negedge resetn_a) begin
    if (!resetn_a) begin
      e = 0; m_sd = 0; m_cpu = 0; m_per = 0; m_err = 0; m_prev = 1;
      sd_up_at = S; win_start = -1; cpu_up_at = -1; per_up_at = -1;
    end else begin
      e = e + 1;
      was_run = m_per;
      rise = soft_reset_req && !m_prev;
      m_prev = soft_reset_req;
      if (sd_up_at == e) begin
        m_sd = 1; win_start = e + 1; sd_up_at = -1;
      end else if (win_start >= 0 && e >= win_start) begin
        if (sdram_init_done) begin
          cpu_up_at = e + S; per_up_at = e + 2 * S; win_start = -1;
        end else if (e == win_start + T - 1) begin
          m_err = 1; m_sd = 0; win_start = -1; sd_up_at = e + S;
        end
      end
      if (cpu_up_at == e) m_cpu = 1;
      if (per_up_at == e) m_per = 1;
      if (was_run && rise) begin
        m_cpu = 0; m_per = 0; cpu_up_at = e + L + S; per_up_at = e + L + 2 * S;
      end
    end
  end

  // Per-cycle compare plus a monitor of the edge on which each output moved.
  logic p_sd = 0, p_cpu = 0, p_per = 0, p_err = 0;
  int sd_rise = -1, sd_fall = -1, cpu_rise = -1, cpu_fall = -1;
  int per_rise = -1, per_fall = -1, err_rise = -1, done_rise = -1, cpu_falls = 0;

  always @(negedge clk_a) begin
    total = total + 1;
    if ({sdram_resetn, cpu_resetn, periph_resetn, seq_done, init_timeout_err} !==
        {m_sd, m_cpu, m_per, m_per, m_err}) begin
      bad = bad + 1;
      $display("FAIL model_cmp edge=%0d got sd/cpu/per/done/err=%b%b%b%b%b want %b%b%b%b%b",
               e, sdram_resetn, cpu_resetn, periph_resetn, seq_done, init_timeout_err,
               m_sd, m_cpu, m_per, m_per, m_err);
    end
    if (resetn_a) begin
      if (sdram_resetn && !p_sd) sd_rise = e;
      if (!sdram_resetn && p_sd) sd_fall = e;
      if (cpu_resetn && !p_cpu) cpu_rise = e;
      if (!cpu_resetn && p_cpu) begin cpu_fall = e; cpu_falls = cpu_falls + 1; end
      if (periph_resetn && !p_per) per_rise = e;
      if (!periph_resetn && p_per) per_fall = e;
      if (init_timeout_err && !p_err) err_rise = e;
      if (seq_done && periph_resetn && !p_per) done_rise = e;
    end
    p_sd = sdram_resetn; p_cpu = cpu_resetn; p_per = periph_resetn; p_err = init_timeout_err;
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic clear_rec();
    sd_rise = -1; sd_fall = -1; cpu_rise = -1; cpu_fall = -1;
    per_rise = -1; per_fall = -1; err_rise = -1; done_rise = -1; cpu_falls = 0;
  endtask

  task automatic do_reset(input logic done_v, input logic req_v);
    @(negedge clk_a);
    resetn_a = 0; sdram_init_done = done_v; soft_reset_req = req_v;
    @(negedge clk_a);
    chk("reset_state", int'({sdram_resetn, cpu_resetn, periph_resetn, seq_done, init_timeout_err}), 0);
    @(negedge clk_a);
    clear_rec();
    resetn_a = 1;
  endtask

  task automatic run_to(input int n);
    int guard = 0;
    while (e < n && guard < 2000) begin
      @(negedge clk_a);
      guard++;
    end
    if (guard >= 2000) begin
      total = total + 1; bad = bad + 1;
      $display("FAIL run_to_timeout got_edge=%0d want_edge=%0d", e, n);
    end
  endtask

  task automatic async_reset_check(input string name);
    #2 resetn_a = 0;
    #1 chk(name, int'({sdram_resetn, cpu_resetn, periph_resetn, seq_done, init_timeout_err}), 0);
  endtask

  task automatic release_cold_and_check(input string tag);
    sdram_init_done = 1; soft_reset_req = 0;
    @(negedge clk_a);
    @(negedge clk_a);
    clear_rec();
    resetn_a = 1;
    run_to(14);
    chk({tag, "_sd_rise"}, sd_rise, 4);
    chk({tag, "_cpu_rise"}, cpu_rise, 9);
    chk({tag, "_per_rise"}, per_rise, 13);
  endtask

  initial begin
    // Cold boot
    do_reset(1, 0);
    run_to(14);
    chk("cold_sd_rise", sd_rise, 4);
    chk("cold_cpu_rise", cpu_rise, 9);
    chk("cold_per_rise", per_rise, 13);
    chk("cold_done_rise", done_rise, 13);

    // Late init: first sampled high on edge 10
    do_reset(0, 0);
    run_to(9);
    sdram_init_done = 1;
    run_to(19);
    chk("late_cpu_rise", cpu_rise, 14);
    chk("late_per_rise", per_rise, 18);
    chk("late_err", int'(init_timeout_err), 0);

    // Timeout and retry
    do_reset(0, 0);
    run_to(39);
    sdram_init_done = 1;
    run_to(50);
    chk("to_sd_fall", sd_fall, 24);
    chk("to_err_rise", err_rise, 24);
    chk("to_sd_rise", sd_rise, 28);
    chk("to_cpu_rise", cpu_rise, 44);
    chk("to_err_held", int'(init_timeout_err), 1);

    // Soft reset at edge 100, second pulse at 105 ignored
    do_reset(1, 0);
    run_to(99);  soft_reset_req = 1;
    run_to(101); soft_reset_req = 0;
    run_to(104); soft_reset_req = 1;
    run_to(106); soft_reset_req = 0;
    run_to(117);
    chk("soft_cpu_fall", cpu_fall, 100);
    chk("soft_per_fall", per_fall, 100);
    chk("soft_sd_fall", sd_fall, -1);
    chk("soft_cpu_rise", cpu_rise, 112);
    chk("soft_per_rise", per_rise, 116);
    chk("soft_count", cpu_falls, 1);

    // Request held high from reset
    do_reset(1, 1);
    run_to(40);
    chk("held_no_soft", cpu_falls, 0);
    soft_reset_req = 0;
    run_to(42); soft_reset_req = 1;
    run_to(70);
    chk("held_one_soft", cpu_falls, 1);
    chk("held_fall_edge", cpu_fall, 43);

    // Reset during SOFT, after a timeout set the sticky error
    do_reset(0, 0);
    run_to(25); sdram_init_done = 1;
    run_to(38);
    chk("mid_err_set", int'(init_timeout_err), 1);
    chk("mid_per_rise", per_rise, 37);
    soft_reset_req = 1;
    run_to(43);
    chk("mid_in_soft", int'({sdram_resetn, cpu_resetn}), 2);
    async_reset_check("async_in_soft");
    release_cold_and_check("after_soft_rst");

    // Reset during PERIPH_DLY
    run_to(0);
    do_reset(1, 0);
    run_to(11);
    async_reset_check("async_in_periph");
    release_cold_and_check("after_periph_rst");

    // Randomized soak against the model
    for (int it = 0; it < 6; it++) begin
      int pd;
      do_reset(1'($urandom_range(1)), 0);
      pd = (it % 2 == 1) ? 3 : 40;
      for (int c = 0; c < 250; c++) begin
        @(negedge clk_a);
        if ($urandom_range(pd) == 0) sdram_init_done = ~sdram_init_done;
        if ($urandom_range(9) == 0) soft_reset_req = ~soft_reset_req;
        if ($urandom_range(299) == 0) begin
          #2 resetn_a = 0;
          @(negedge clk_a);
          resetn_a = 1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
